// File: rtl/alu_seq.sv
// Operand sequencer and result register around the 16-bit combinational ALU.
// Collects operands from the shared bus, drives the ALU for one cycle and registers the result.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; illegal op raises a one-cycle err pulse
// LOAD_A | waiting for bus_valid to capture operand A
// LOAD_B | waiting for bus_valid to capture operand B (two-operand ops)
// EXEC   | alu_sel driven with op_reg; ALU result captured at the edge
// DONE   | result_valid pulse, then back to IDLE
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SELW  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SELW-1:0]  op,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_valid,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_c,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        DONE
    } state_t;

    localparam logic [SELW-1:0] OP_AND  = SELW'(1);
    localparam logic [SELW-1:0] OP_OR   = SELW'(2);
    localparam logic [SELW-1:0] OP_XOR  = SELW'(3);
    localparam logic [SELW-1:0] OP_ADD  = SELW'(5);
    localparam logic [SELW-1:0] OP_SUB  = SELW'(6);
    localparam logic [SELW-1:0] OP_ZERO = SELW'(9);

    state_t           state;
    state_t           state_nxt;
    logic [SELW-1:0]  op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             accept;
    logic             illegal;
    logic             two_op;

    assign accept  = (state == IDLE) && start && (op <= OP_ZERO);
    assign illegal = (state == IDLE) && start && (op >  OP_ZERO);
    assign two_op  = (op_reg == OP_AND) || (op_reg == OP_OR) || (op_reg == OP_XOR) ||
                     (op_reg == OP_ADD) || (op_reg == OP_SUB);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (op == OP_ZERO) ? EXEC : LOAD_A;
                end
            end
            LOAD_A: begin
                if (bus_valid) begin
                    state_nxt = two_op ? LOAD_B : EXEC;
                end
            end
            LOAD_B: begin
                if (bus_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        result_valid = (state == DONE);
        alu_sel      = '0;
        if (state == EXEC) begin
            alu_sel = op_reg;
        end
    end

    // Operand, opcode and result registers; result and flags only move in EXEC.
    always_ff @(posedge clock) begin
        if (!reset) begin
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= illegal;
            if (accept) begin
                op_reg <= op;
            end
            if ((state == LOAD_A) && bus_valid) begin
                a_reg <= bus_in;
            end
            if ((state == LOAD_B) && bus_valid) begin
                b_reg <= bus_in;
            end
            if (state == EXEC) begin
                result    <= alu_c;
                zero_flag <= (alu_c == '0);
                neg_flag  <= alu_c[WIDTH-1];
            end
        end
    end

    assign alu_a = a_reg;
    assign alu_b = b_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, random operations against a
// behavioural model, plus hand-written reset, illegal-op and ignored-start sequences.
module tb_alu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [15:0] bus_in;
    logic        bus_valid;
    logic        busy;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_c;
    logic [15:0] result;
    logic        result_valid;
    logic        zero_flag;
    logic        neg_flag;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_a     = 16'h0000;
    logic [15:0] model_b     = 16'h0000;
    logic [15:0] last_result = 16'h0000;

    typedef struct {
        int          op;
        logic [15:0] a;
        logic [15:0] b;
        int          sa;
        int          sb;
        bit          poke;
        logic [15:0] res;
        bit          z;
        bit          n;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    alu_seq #(.WIDTH(16), .SELW(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .bus_in       (bus_in),
        .bus_valid    (bus_valid),
        .busy         (busy),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_c        (alu_c),
        .result       (result),
        .result_valid (result_valid),
        .zero_flag    (zero_flag),
        .neg_flag     (neg_flag),
        .err          (err)
    );

    function automatic logic [15:0] ref_alu(input int sel, input logic [15:0] a, input logic [15:0] b);
        case (sel)
            0:       return a;
            1:       return a & b;
            2:       return a | b;
            3:       return a ^ b;
            4:       return ~a;
            5:       return a + b;
            6:       return a - b;
            7:       return a + 16'd1;
            8:       return a - 16'd1;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit is_two(input int o);
        return (o == 1) || (o == 2) || (o == 3) || (o == 5) || (o == 6);
    endfunction

    // The ALU itself is external to the DUT; model it combinationally here.
    assign alu_c = ref_alu(int'(alu_sel), alu_a, alu_b);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input int opc, input logic [15:0] a, input logic [15:0] b,
                         input int sa, input int sb, input bit poke,
                         input logic [15:0] exp_res, input bit exp_z, input bit exp_n,
                         input int exp_lat, input string tag);
        int ca;
        int cb;
        int lat;
        bit got;
        ca  = sa + 1;
        cb  = ca + sb + 1;
        lat = 0;
        got = 0;
        @(posedge clock); #1;
        start     = 1'b1;
        op        = 4'(opc);
        bus_valid = 1'b0;
        bus_in    = 16'($urandom);
        @(negedge clock);
        check({tag, " idle busy"}, 32'(busy), 32'(0));
        check({tag, " idle result_valid"}, 32'(result_valid), 32'(0));
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clock); #1;
            start     = poke;
            op        = (c % 2 == 1) ? 4'd9 : 4'd13;
            bus_in    = 16'($urandom);
            bus_valid = 1'b1;
            if (opc != 9) begin
                if (c < ca || (is_two(opc) && c > ca && c < cb)) bus_valid = 1'b0;
                else if (c == ca) bus_in = a;
                else if (is_two(opc) && c == cb) bus_in = b;
            end
            @(negedge clock);
            if (result_valid === 1'b1) begin
                got = 1;
                lat = c;
            end
            check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(1));
            check($sformatf("%s err c%0d", tag, c), 32'(err), 32'(0));
            check($sformatf("%s alu_sel c%0d", tag, c), 32'(alu_sel),
                  (c == exp_lat - 1) ? 32'(opc) : 32'(0));
        end
        start     = 1'b0;
        bus_valid = 1'b0;
        if (opc != 9) model_a = a;
        if (is_two(opc)) model_b = b;
        last_result = exp_res;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " zero_flag"}, 32'(zero_flag), 32'(exp_z));
        check({tag, " neg_flag"}, 32'(neg_flag), 32'(exp_n));
        check({tag, " alu_a"}, 32'(alu_a), 32'(model_a));
        check({tag, " alu_b"}, 32'(alu_b), 32'(model_b));
    endtask

    task automatic do_illegal(input int opc);
        @(posedge clock); #1;
        start     = 1'b1;
        op        = 4'(opc);
        bus_valid = 1'b1;
        bus_in    = 16'($urandom);
        @(negedge clock);
        check("illegal pre busy", 32'(busy), 32'(0));
        @(posedge clock); #1;
        start     = 1'b0;
        bus_valid = 1'b0;
        @(negedge clock);
        check($sformatf("illegal op%0d err", opc), 32'(err), 32'(1));
        check($sformatf("illegal op%0d busy", opc), 32'(busy), 32'(0));
        check($sformatf("illegal op%0d result", opc), 32'(result), 32'(last_result));
        check($sformatf("illegal op%0d alu_a", opc), 32'(alu_a), 32'(model_a));
        @(posedge clock); #1;
        @(negedge clock);
        check($sformatf("illegal op%0d err pulse end", opc), 32'(err), 32'(0));
        check($sformatf("illegal op%0d busy after", opc), 32'(busy), 32'(0));
    endtask

    initial begin
        vecs[0]  = '{5, 16'hFFFF, 16'h0001, 0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 4};
        vecs[1]  = '{6, 16'h0003, 16'h0005, 0, 3, 1'b0, 16'hFFFE, 1'b0, 1'b1, 7};
        vecs[2]  = '{4, 16'h00F0, 16'h1234, 0, 0, 1'b0, 16'hFF0F, 1'b0, 1'b1, 3};
        vecs[3]  = '{8, 16'h0000, 16'h5678, 0, 0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 3};
        vecs[4]  = '{9, 16'hDEAD, 16'hBEEF, 0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 2};
        vecs[5]  = '{1, 16'hF0F0, 16'hFF00, 0, 0, 1'b0, 16'hF000, 1'b0, 1'b1, 4};
        vecs[6]  = '{2, 16'h0F00, 16'h00F0, 0, 0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 4};
        vecs[7]  = '{3, 16'hAAAA, 16'hAAAA, 0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 4};
        vecs[8]  = '{7, 16'h7FFF, 16'h0000, 0, 0, 1'b0, 16'h8000, 1'b0, 1'b1, 3};
        vecs[9]  = '{0, 16'h8001, 16'h0000, 2, 0, 1'b0, 16'h8001, 1'b0, 1'b1, 5};
        vecs[10] = '{6, 16'h0005, 16'h0005, 1, 1, 1'b0, 16'h0000, 1'b1, 1'b0, 6};
        vecs[11] = '{5, 16'h1234, 16'h1111, 0, 0, 1'b1, 16'h2345, 1'b0, 1'b0, 4};

        reset     = 1'b0;
        start     = 1'b0;
        op        = 4'd0;
        bus_in    = 16'h0000;
        bus_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset busy", 32'(busy), 32'(0));
        check("reset result_valid", 32'(result_valid), 32'(0));
        check("reset err", 32'(err), 32'(0));
        check("reset result", 32'(result), 32'(0));
        check("reset zero_flag", 32'(zero_flag), 32'(0));
        check("reset neg_flag", 32'(neg_flag), 32'(0));
        check("reset alu_a", 32'(alu_a), 32'(0));
        check("reset alu_b", 32'(alu_b), 32'(0));
        check("reset alu_sel", 32'(alu_sel), 32'(0));
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].poke,
                  vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].lat, $sformatf("vec%0d", i));
        end

        do_illegal(12);
        do_illegal(15);

        for (int i = 0; i < 40; i++) begin
            int          r;
            int          sa;
            int          sb;
            int          el;
            logic [15:0] a;
            logic [15:0] b;
            logic [15:0] e;
            r = int'($urandom_range(0, 11));
            if (r >= 10) begin
                do_illegal(int'($urandom_range(10, 15)));
            end else begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                sa = int'($urandom_range(0, 2));
                sb = int'($urandom_range(0, 2));
                if (r == 9) el = 2;
                else if (is_two(r)) el = sa + sb + 4;
                else el = sa + 3;
                e = ref_alu(r, is_two(r) || r != 9 ? a : model_a, is_two(r) ? b : model_b);
                do_op(r, a, b, sa, sb, ($urandom_range(0, 3) == 0), e, (e == 16'h0000), e[15],
                      el, $sformatf("rnd%0d op%0d", i, r));
            end
        end

        // Reset while waiting for operand B must discard the operation.
        do_op(7, 16'h4000, 16'h0000, 0, 0, 1'b0, 16'h4001, 1'b0, 1'b0, 3, "pre-reset");
        @(posedge clock); #1;
        start     = 1'b1;
        op        = 4'd5;
        bus_valid = 1'b0;
        @(posedge clock); #1;
        start     = 1'b0;
        bus_valid = 1'b1;
        bus_in    = 16'hABCD;
        @(posedge clock); #1;
        bus_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        check("midreset load_b busy", 32'(busy), 32'(1));
        check("midreset load_b alu_a", 32'(alu_a), 32'(16'hABCD));
        @(posedge clock); #1;
        reset     = 1'b1;
        bus_valid = 1'b1;
        bus_in    = 16'h5A5A;
        @(negedge clock);
        check("midreset busy", 32'(busy), 32'(0));
        check("midreset result_valid", 32'(result_valid), 32'(0));
        check("midreset err", 32'(err), 32'(0));
        check("midreset result", 32'(result), 32'(0));
        check("midreset zero_flag", 32'(zero_flag), 32'(0));
        check("midreset neg_flag", 32'(neg_flag), 32'(0));
        check("midreset alu_a", 32'(alu_a), 32'(0));
        check("midreset alu_b", 32'(alu_b), 32'(0));
        check("midreset alu_sel", 32'(alu_sel), 32'(0));
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            bus_in = 16'($urandom);
            @(negedge clock);
            check($sformatf("post-reset result_valid c%0d", c), 32'(result_valid), 32'(0));
            check($sformatf("post-reset busy c%0d", c), 32'(busy), 32'(0));
        end
        bus_valid   = 1'b0;
        model_a     = 16'h0000;
        model_b     = 16'h0000;
        last_result = 16'h0000;
        do_op(3, 16'h00FF, 16'h0F0F, 0, 0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 4, "recover");
        @(posedge clock); #1;
        @(negedge clock);
        check("tail busy", 32'(busy), 32'(0));
        check("tail result_valid", 32'(result_valid), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
